// File: rtl/sw_debounce_pkg.sv
// sw_debounce_pkg: shared state type and default timing constants for the button conditioner.
package sw_debounce_pkg;
  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;
  localparam int DEF_DEBOUNCE_CNT = 100000;
  localparam int DEF_LONG_CNT = 10000000;
  localparam int DEF_REPEAT_CNT = 2000000;
  function automatic int max_cnt(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/sw_filter.sv
// sw_filter: synchronizes the raw active-low button and debounces it into a clean level.
module sw_filter
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_en,
  input  logic i_sw_n,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  logic [1:0] sync;
  logic [DW-1:0] cnt;
  logic mismatch, toggle;
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) sync <= 2'b11;
    else sync <= {sync[0], i_sw_n};
  assign mismatch = ~sync[1] != o_level;
  assign toggle = i_en && mismatch && cnt == DW'(DEBOUNCE_CNT - 1);
  // Strobes fire the cycle before o_level flips so the top can register events in step with it.
  assign o_rise = toggle & ~o_level;
  assign o_fall = toggle & o_level;
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) begin
      cnt <= '0;
      o_level <= 1'b0;
    end else if (!i_en) begin
      cnt <= '0;
      o_level <= 1'b0;
    end else if (!mismatch || toggle) begin
      cnt <= '0;
      o_level <= o_level ^ toggle;
    end else begin
      cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sw_debounce.sv
// sw_debounce: clean button level plus press, release, long-press and auto-repeat pulses.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int LONG_CNT = DEF_LONG_CNT,
  parameter int REPEAT_CNT = DEF_REPEAT_CNT
) (
  input  logic i_clk,
  input  logic i_res_n,
  input  logic i_en,
  input  logic i_sw_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);
  localparam int HW = $clog2(max_cnt(LONG_CNT, REPEAT_CNT));
  state_t state, state_n;
  logic [HW-1:0] cnt, cnt_n;
  logic rise, fall, press_n, release_n, long_n, repeat_n;
  sw_filter #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_filter (
    .i_clk(i_clk),
    .i_res_n(i_res_n),
    .i_en(i_en),
    .i_sw_n(i_sw_n),
    .o_level(o_level),
    .o_rise(rise),
    .o_fall(fall)
  );
  always_ff @(posedge i_clk or negedge i_res_n)
    if (!i_res_n) begin
      state <= IDLE;
      cnt <= '0;
      {o_press, o_release, o_long, o_repeat} <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      {o_press, o_release, o_long, o_repeat} <= {press_n, release_n, long_n, repeat_n};
    end
  // Release is checked first so it suppresses a coincident long/repeat event.
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    {press_n, release_n, long_n, repeat_n} = '0;
    if (!i_en) begin
      state_n = IDLE;
      cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n = '0;
          press_n = rise;
          state_n = rise ? HELD : IDLE;
        end
        HELD, LONG: begin
          if (fall) begin
            release_n = 1'b1;
            cnt_n = '0;
            state_n = IDLE;
          end else if (state == HELD && cnt == HW'(LONG_CNT - 1)) begin
            long_n = 1'b1;
            cnt_n = '0;
            state_n = LONG;
          end else if (state == LONG && cnt == HW'(REPEAT_CNT - 1)) begin
            repeat_n = 1'b1;
            cnt_n = '0;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n = '0;
        end
      endcase
    end
  end
endmodule
